// File: rtl/ovl_fabric_sched.sv
// Run-control sequencer for a bank of ovl_combo checker slots: host config port,
// bank validation before arming, warm-up blanking, fire capture with irq/ack.
//
// state  | meaning
// IDLE   | config writes accepted, slots disabled
// CHECK  | one-cycle validation of the whole bank
// ARMED  | slots enabled, fires honoured once the blank counter reaches 0
// FIRED  | bank frozen, irq raised until ack or disarm
module ovl_fabric_sched #(
    parameter int NUM_SLOTS     = 4,
    parameter int SLOT_IDX_W    = 2,
    parameter int NUM_CKS_WIDTH = 3,
    parameter int BLANK_CYCLES  = 7
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_cfg_valid,
    output logic                               o_cfg_ready,
    input  logic [SLOT_IDX_W-1:0]              i_cfg_slot,
    input  logic [NUM_CKS_WIDTH-1:0]           i_cfg_num_cks,
    input  logic [1:0]                         i_cfg_select,
    input  logic                               i_arm_req,
    input  logic                               i_disarm_req,
    input  logic                               i_irq_ack,
    output logic [NUM_SLOTS*NUM_CKS_WIDTH-1:0] o_slot_num_cks,
    output logic [NUM_SLOTS*2-1:0]             o_slot_select,
    output logic [NUM_SLOTS-1:0]               o_slot_enable,
    input  logic [NUM_SLOTS-1:0]               i_slot_fire,
    output logic                               o_cfg_invalid,
    output logic                               o_busy,
    output logic                               o_irq,
    output logic [NUM_SLOTS-1:0]               o_fire_mask,
    output logic [SLOT_IDX_W-1:0]              o_fire_slot
);
    localparam int CNT_W = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_ARMED, ST_FIRED} state_t;

    state_t                             r_state, w_state_nxt;
    logic [NUM_SLOTS*NUM_CKS_WIDTH-1:0] r_num_cks;
    logic [NUM_SLOTS*2-1:0]             r_select;
    logic [NUM_SLOTS-1:0]               r_used;
    logic [CNT_W-1:0]                   r_cnt;
    logic                               r_irq;
    logic [NUM_SLOTS-1:0]               r_fire_mask;
    logic [SLOT_IDX_W-1:0]              r_fire_slot;
    logic                               r_cfg_invalid;

    logic                  w_cfg_hs;
    logic [NUM_SLOTS-1:0]  w_slot_bad;
    logic                  w_bank_invalid;
    logic [NUM_SLOTS-1:0]  w_fire_hit;
    logic                  w_fire_legal;
    logic [SLOT_IDX_W-1:0] w_lowest;
    logic                  w_load_cnt;
    logic                  w_capture;
    logic                  w_ack;
    logic                  w_set_inv;

    assign w_cfg_hs     = i_cfg_valid & (r_state == ST_IDLE);
    assign w_fire_hit   = i_slot_fire & r_used;
    assign w_fire_legal = (r_cnt == '0) & (|w_fire_hit);

    // A slot with zero num_cks is only meaningful when select[1] picks a mode that ignores it.
    always_comb begin
        w_slot_bad = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_slot_bad[i] = r_used[i] & (r_num_cks[i*NUM_CKS_WIDTH +: NUM_CKS_WIDTH] == '0)
                            & ~r_select[2*i+1];
        end
    end
    assign w_bank_invalid = (|w_slot_bad) | (r_used == '0);

    always_comb begin
        w_lowest = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_fire_hit[i]) w_lowest = SLOT_IDX_W'(i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_cnt  = 1'b0;
        w_capture   = 1'b0;
        w_ack       = 1'b0;
        w_set_inv   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_arm_req) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (i_disarm_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_bank_invalid) begin
                    w_state_nxt = ST_IDLE;
                    w_set_inv   = 1'b1;
                end else begin
                    w_state_nxt = ST_ARMED;
                    w_load_cnt  = 1'b1;
                end
            end
            ST_ARMED: begin
                if (i_disarm_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_fire_legal) begin
                    w_state_nxt = ST_FIRED;
                    w_capture   = 1'b1;
                end
            end
            ST_FIRED: begin
                if (i_disarm_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_irq_ack) begin
                    w_state_nxt = ST_ARMED;
                    w_ack       = 1'b1;
                    w_load_cnt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_num_cks     <= '0;
            r_select      <= '0;
            r_used        <= '0;
            r_cnt         <= '0;
            r_irq         <= 1'b0;
            r_fire_mask   <= '0;
            r_fire_slot   <= '0;
            r_cfg_invalid <= 1'b0;
        end else begin
            if (w_cfg_hs) begin
                r_num_cks[i_cfg_slot*NUM_CKS_WIDTH +: NUM_CKS_WIDTH] <= i_cfg_num_cks;
                r_select[i_cfg_slot*2 +: 2]                          <= i_cfg_select;
                r_used[i_cfg_slot]                                   <= 1'b1;
            end
            if (w_set_inv)     r_cfg_invalid <= 1'b1;
            else if (w_cfg_hs) r_cfg_invalid <= 1'b0;

            if (w_load_cnt)                                r_cnt <= CNT_W'(BLANK_CYCLES);
            else if (r_state == ST_ARMED && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;

            // Disarm keeps fire_mask so the host can still read what last fired.
            if (w_capture) begin
                r_irq       <= 1'b1;
                r_fire_mask <= w_fire_hit;
                r_fire_slot <= w_lowest;
            end else if (w_ack) begin
                r_irq       <= 1'b0;
                r_fire_mask <= '0;
            end else if (w_state_nxt == ST_IDLE) begin
                r_irq       <= 1'b0;
            end
        end
    end

    assign o_cfg_ready    = (r_state == ST_IDLE);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_slot_enable  = (r_state == ST_ARMED) ? r_used : '0;
    assign o_slot_num_cks = r_num_cks;
    assign o_slot_select  = r_select;
    assign o_cfg_invalid  = r_cfg_invalid;
    assign o_irq          = r_irq;
    assign o_fire_mask    = r_fire_mask;
    assign o_fire_slot    = r_fire_slot;
endmodule

// File: tb/tb_ovl_fabric_sched.sv
// Directed bench for ovl_fabric_sched: expectations are queued as each step is driven
// and drained against the DUT outputs one cycle-sample later.
module tb_ovl_fabric_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready;
    logic [1:0]  cfg_slot;
    logic [2:0]  cfg_num_cks;
    logic [1:0]  cfg_select;
    logic        arm_req, disarm_req, irq_ack;
    logic [11:0] slot_num_cks;
    logic [7:0]  slot_select;
    logic [3:0]  slot_enable, slot_fire;
    logic        cfg_invalid, busy, irq;
    logic [3:0]  fire_mask;
    logic [1:0]  fire_slot;

    int n_assert = 0;
    int n_fail   = 0;

    typedef enum {ID_READY, ID_BUSY, ID_EN, ID_IRQ, ID_MASK, ID_FSLOT, ID_INV, ID_NCKS, ID_SEL} sig_e;
    typedef struct {
        string       tag;
        sig_e        id;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ovl_fabric_sched dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cfg_valid    (cfg_valid),
        .o_cfg_ready    (cfg_ready),
        .i_cfg_slot     (cfg_slot),
        .i_cfg_num_cks  (cfg_num_cks),
        .i_cfg_select   (cfg_select),
        .i_arm_req      (arm_req),
        .i_disarm_req   (disarm_req),
        .i_irq_ack      (irq_ack),
        .o_slot_num_cks (slot_num_cks),
        .o_slot_select  (slot_select),
        .o_slot_enable  (slot_enable),
        .i_slot_fire    (slot_fire),
        .o_cfg_invalid  (cfg_invalid),
        .o_busy         (busy),
        .o_irq          (irq),
        .o_fire_mask    (fire_mask),
        .o_fire_slot    (fire_slot)
    );

    function automatic logic [31:0] observe(sig_e id);
        case (id)
            ID_READY: return 32'(cfg_ready);
            ID_BUSY:  return 32'(busy);
            ID_EN:    return 32'(slot_enable);
            ID_IRQ:   return 32'(irq);
            ID_MASK:  return 32'(fire_mask);
            ID_FSLOT: return 32'(fire_slot);
            ID_INV:   return 32'(cfg_invalid);
            ID_NCKS:  return 32'(slot_num_cks);
            ID_SEL:   return 32'(slot_select);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_val(input string tag, input sig_e id, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.id = id; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.id);
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] s, input logic [2:0] n, input logic [1:0] sel);
        cfg_valid = 1'b1; cfg_slot = s; cfg_num_cks = n; cfg_select = sel;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic idle_expect(input string tag);
        expect_val({tag, "_busy"},  ID_BUSY,  0);
        expect_val({tag, "_ready"}, ID_READY, 1);
        expect_val({tag, "_en"},    ID_EN,    0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_slot = '0; cfg_num_cks = '0; cfg_select = '0;
        arm_req = 1'b0; disarm_req = 1'b0; irq_ack = 1'b0; slot_fire = '0;
        #12 rst_n = 1'b1;

        // Reset values
        idle_expect("rst");
        expect_val("rst_irq",  ID_IRQ,   0);
        expect_val("rst_mask", ID_MASK,  0);
        expect_val("rst_fslot",ID_FSLOT, 0);
        expect_val("rst_inv",  ID_INV,   0);
        expect_val("rst_ncks", ID_NCKS,  0);
        expect_val("rst_sel",  ID_SEL,   0);
        drain();

        // 1: slot0 valid config, arm passes through CHECK into ARMED
        cfg_write(2'd0, 3'd3, 2'b00);
        expect_val("t1_ncks", ID_NCKS, 12'h003);
        expect_val("t1_sel",  ID_SEL,  0);
        drain();
        arm_req = 1'b1; tick(); arm_req = 1'b0;
        expect_val("t1_chk_busy", ID_BUSY,  1);
        expect_val("t1_chk_rdy",  ID_READY, 0);
        expect_val("t1_chk_en",   ID_EN,    0);
        drain();
        tick();
        expect_val("t1_arm_en",  ID_EN,  4'b0001);
        expect_val("t1_arm_inv", ID_INV, 0);
        drain();
        disarm_req = 1'b1; tick(); disarm_req = 1'b0;
        idle_expect("t1_dis");
        drain();

        // 2: slot1 with num_cks=0, sel[1]=0 rejects the bank; rewrite fixes it
        cfg_write(2'd1, 3'd0, 2'b01);
        expect_val("t2_sel", ID_SEL, 8'h04);
        drain();
        arm_req = 1'b1; tick(); arm_req = 1'b0;
        expect_val("t2_chk_en", ID_EN, 0);
        drain();
        tick();
        idle_expect("t2_rej");
        expect_val("t2_inv", ID_INV, 1);
        drain();
        cfg_write(2'd1, 3'd0, 2'b10);
        expect_val("t2_inv_clr", ID_INV, 0);
        expect_val("t2_sel2",    ID_SEL, 8'h08);
        drain();
        arm_req = 1'b1; tick(); arm_req = 1'b0; tick();
        expect_val("t2_arm_en", ID_EN, 4'b0011);
        drain();
        disarm_req = 1'b1; tick(); disarm_req = 1'b0;

        // 3: fresh bank with slots 0 and 2; fire ignored while blanked, captured at count 0
        rst_n = 1'b0; #3 rst_n = 1'b1;
        cfg_write(2'd0, 3'd3, 2'b00);
        cfg_write(2'd2, 3'd1, 2'b01);
        expect_val("t3_ncks", ID_NCKS, 12'h043);
        expect_val("t3_sel",  ID_SEL,  8'h10);
        drain();
        arm_req = 1'b1; tick(); arm_req = 1'b0; tick();
        repeat (3) tick();
        slot_fire = 4'b0101; tick(); slot_fire = '0;
        expect_val("t3_blank_irq", ID_IRQ, 0);
        expect_val("t3_blank_en",  ID_EN,  4'b0101);
        expect_val("t3_blank_msk", ID_MASK, 0);
        drain();
        repeat (3) tick();
        slot_fire = 4'b0101; tick(); slot_fire = '0;
        expect_val("t3_fire_irq",  ID_IRQ,   1);
        expect_val("t3_fire_mask", ID_MASK,  4'b0101);
        expect_val("t3_fire_slot", ID_FSLOT, 0);
        expect_val("t3_fire_en",   ID_EN,    0);
        expect_val("t3_fire_busy", ID_BUSY,  1);
        drain();

        // 4: ack re-arms with a fresh blank window; unused-slot fire never captures
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        expect_val("t4_ack_irq",  ID_IRQ,  0);
        expect_val("t4_ack_mask", ID_MASK, 0);
        expect_val("t4_ack_en",   ID_EN,   4'b0101);
        drain();
        repeat (6) tick();
        slot_fire = 4'b0100; tick(); slot_fire = '0;
        expect_val("t4_cyc6_irq", ID_IRQ, 0);
        drain();
        slot_fire = 4'b1010; tick(); slot_fire = '0;
        expect_val("t4_unused_irq", ID_IRQ, 0);
        drain();
        slot_fire = 4'b0100; tick(); slot_fire = '0;
        expect_val("t4_fire_irq",  ID_IRQ,   1);
        expect_val("t4_fire_mask", ID_MASK,  4'b0100);
        expect_val("t4_fire_slot", ID_FSLOT, 2);
        drain();

        // 5: disarm beats ack in FIRED, and beats a legal fire in ARMED
        irq_ack = 1'b1; disarm_req = 1'b1; tick(); irq_ack = 1'b0; disarm_req = 1'b0;
        idle_expect("t5_ackdis");
        expect_val("t5_ackdis_irq",  ID_IRQ,  0);
        expect_val("t5_ackdis_mask", ID_MASK, 4'b0100);
        drain();
        arm_req = 1'b1; tick(); arm_req = 1'b0; tick();
        repeat (7) tick();
        slot_fire = 4'b0001; disarm_req = 1'b1; tick(); slot_fire = '0; disarm_req = 1'b0;
        idle_expect("t5_firedis");
        expect_val("t5_firedis_irq",  ID_IRQ,  0);
        expect_val("t5_firedis_mask", ID_MASK, 4'b0100);
        drain();

        // 6: config stalls while armed, lands in first IDLE cycle; async reset mid-run
        arm_req = 1'b1; tick(); arm_req = 1'b0; tick();
        cfg_valid = 1'b1; cfg_slot = 2'd3; cfg_num_cks = 3'd5; cfg_select = 2'b11;
        tick(); tick();
        expect_val("t6_stall_rdy",  ID_READY, 0);
        expect_val("t6_stall_ncks", ID_NCKS,  12'h043);
        expect_val("t6_stall_sel",  ID_SEL,   8'h10);
        drain();
        disarm_req = 1'b1; tick(); disarm_req = 1'b0;
        expect_val("t6_idle_rdy", ID_READY, 1);
        expect_val("t6_idle_ncks", ID_NCKS, 12'h043);
        drain();
        tick(); cfg_valid = 1'b0;
        expect_val("t6_acc_ncks", ID_NCKS, 12'hA43);
        expect_val("t6_acc_sel",  ID_SEL,  8'hD0);
        drain();
        arm_req = 1'b1; tick(); arm_req = 1'b0; tick();
        expect_val("t6_arm_en", ID_EN, 4'b1101);
        drain();
        #2 rst_n = 1'b0;
        #1;
        idle_expect("t6_rst");
        expect_val("t6_rst_mask", ID_MASK, 0);
        expect_val("t6_rst_ncks", ID_NCKS, 0);
        expect_val("t6_rst_sel",  ID_SEL,  0);
        expect_val("t6_rst_irq",  ID_IRQ,  0);
        drain();
        #3 rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
